// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle synchronous imem,
// and skids the presented instruction across stalls. Optional IF_PERF_CNT_EN adds fetch/stall counters.
module if_fetch_unit #(
  parameter int unsigned         ADDR_W    = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC  = '0,
  parameter logic [0:31]         NOP_INSTR = 32'hE000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_en,
  input  logic [0:31]       imem_dout,
  output logic [0:31]       IF_Instr,
  output logic [ADDR_W-1:0] IF_pc,
  output logic              IF_valid,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt,
`endif
  output logic              flush
);

  // Handshake: an instruction with IF_valid=1 is consumed by IF/ID on any edge
  // where stall=0; with stall=1 the presented instruction must stay unchanged.
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic              hold_valid_q, hold_valid_d;
  logic [0:31]       hold_instr_q, hold_instr_d;
  logic [ADDR_W-1:0] hold_pc_q, hold_pc_d;

  logic [0:31]       out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic              out_valid;

  // Skid register has priority over the in-flight read.
  always_comb begin
    out_instr = NOP_INSTR;
    out_pc    = pend_pc_q;
    out_valid = 1'b0;
    if (hold_valid_q) begin
      out_instr = hold_instr_q;
      out_pc    = hold_pc_q;
      out_valid = 1'b1;
    end else if (pend_valid_q) begin
      out_instr = imem_dout;
      out_pc    = pend_pc_q;
      out_valid = 1'b1;
    end
  end

  assign IF_Instr  = (rst || branch_taken) ? NOP_INSTR : out_instr;
  assign IF_pc     = out_pc;
  assign IF_valid  = !rst && !branch_taken && out_valid;
  assign imem_en   = !rst && (branch_taken || !stall);
  assign imem_addr = branch_taken ? branch_target : pc_q;
  assign flush     = !rst && branch_taken;

  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    hold_pc_d    = hold_pc_q;
    if (branch_taken) begin
      pc_d         = branch_target + ADDR_W'(1);
      pend_valid_d = 1'b1;
      pend_pc_d    = branch_target;
      hold_valid_d = 1'b0;
    end else if (stall) begin
      pend_valid_d = 1'b0;
      // Capture only once so the output stays frozen for the whole stall.
      if (!hold_valid_q) begin
        hold_valid_d = out_valid;
        hold_instr_d = out_instr;
        hold_pc_d    = out_pc;
      end
    end else begin
      pc_d         = pc_q + ADDR_W'(1);
      pend_valid_d = 1'b1;
      pend_pc_d    = pc_q;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= RESET_PC;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (IF_valid && !stall && !branch_taken) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (stall) stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios plus randomized
// stall/branch/reset traffic checked against a sequence-level fetch model.
module tb_if_fetch_unit;

  localparam logic [0:31] NOP = 32'hE000_0000;

  logic        clk;
  logic        rst, stall, branch_taken;
  logic [7:0]  branch_target;
  logic [7:0]  imem_addr;
  logic        imem_en;
  logic [0:31] imem_dout;
  logic [0:31] IF_Instr;
  logic [7:0]  IF_pc;
  logic        IF_valid;
  logic        flush;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [256];

  if_fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_en(imem_en), .imem_dout(imem_dout),
    .IF_Instr(IF_Instr), .IF_pc(IF_pc), .IF_valid(IF_valid),
`ifdef IF_PERF_CNT_EN
    .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
    .flush(flush)
  );

  // clock / memory
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial imem_dout = '0;
  always @(posedge clk) if (imem_en) imem_dout <= mem[imem_addr];

  // Reference model: which instruction is presented and which address comes next.
  logic        m_valid;
  logic [7:0]  m_pc;
  logic [7:0]  m_next;
  logic [31:0] m_fetch_cnt, m_stall_cnt;

  initial begin
    m_valid = 1'b0; m_pc = 8'h00; m_next = 8'h00;
    m_fetch_cnt = 0; m_stall_cnt = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0;
      m_next  = 8'h00;
      m_fetch_cnt = 0;
      m_stall_cnt = 0;
    end else begin
      if (stall) m_stall_cnt = m_stall_cnt + 1;
      if (branch_taken) begin
        m_valid = 1'b1;
        m_pc    = branch_target;
        m_next  = branch_target + 8'd1;
      end else if (!stall) begin
        if (m_valid) m_fetch_cnt = m_fetch_cnt + 1;
        m_valid = 1'b1;
        m_pc    = m_next;
        m_next  = m_next + 8'd1;
      end
    end
  end

  function automatic logic exp_valid();
    return !rst && !branch_taken && m_valid;
  endfunction
  function automatic logic [0:31] exp_instr();
    return exp_valid() ? mem[m_pc] : NOP;
  endfunction
  function automatic logic exp_en();
    return !rst && (branch_taken || !stall);
  endfunction
  function automatic logic [7:0] exp_addr();
    return branch_taken ? branch_target : m_next;
  endfunction

  // driver: inputs change just after posedge, outputs sampled at negedge
  task automatic drive(input logic r, input logic s, input logic b, input logic [7:0] t);
    @(posedge clk);
    #1;
    rst = r; stall = s; branch_taken = b; branch_target = t;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 0, 8'h00);
      n_checks++;
      if (imem_en !== 1'b0 || flush !== 1'b0 || IF_valid !== 1'b0 || IF_Instr !== NOP) begin
        n_fail++;
        $display("FAIL reset_outputs: en=%b flush=%b valid=%b instr=%h, want en=0 flush=0 valid=0 instr=%h",
                 imem_en, flush, IF_valid, IF_Instr, NOP);
      end
    end
    drive(0, 0, 0, 8'h00);
    n_checks++;
    if (IF_valid !== 1'b0 || IF_Instr !== NOP || imem_en !== 1'b1 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL fill_bubble: valid=%b instr=%h en=%b addr=%h, want 0 %h 1 00",
               IF_valid, IF_Instr, imem_en, imem_addr, NOP);
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 8'h00);
      n_checks++;
      if (IF_valid !== 1'b1 || IF_pc !== 8'(i) || IF_Instr !== 32'hA800_0000 + 32'(i)) begin
        n_fail++;
        $display("FAIL free_run[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h",
                 i, IF_valid, IF_pc, IF_Instr, 8'(i), 32'hA800_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 4; i++) begin
      drive(0, (i < 3), 0, 8'h00);
      n_checks++;
      if (IF_valid !== 1'b1 || IF_pc !== 8'h04 || IF_Instr !== 32'hA800_0004 || imem_en !== (i == 3)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: valid=%b pc=%h instr=%h en=%b, want 1 04 a8000004 %b",
                 i, IF_valid, IF_pc, IF_Instr, imem_en, (i == 3));
      end
    end
    drive(0, 0, 0, 8'h00);
    n_checks++;
    if (IF_valid !== 1'b1 || IF_pc !== 8'h05 || IF_Instr !== 32'hA800_0005) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b pc=%h instr=%h, want 1 05 a8000005", IF_valid, IF_pc, IF_Instr);
    end
  endtask

  task automatic test_branch();
    drive(0, 0, 1, 8'h40);
    n_checks++;
    if (flush !== 1'b1 || IF_valid !== 1'b0 || imem_addr !== 8'h40 || imem_en !== 1'b1 || IF_Instr !== NOP) begin
      n_fail++;
      $display("FAIL branch_cycle: flush=%b valid=%b addr=%h en=%b instr=%h, want 1 0 40 1 %h",
               flush, IF_valid, imem_addr, imem_en, IF_Instr, NOP);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 8'h00);
      n_checks++;
      if (IF_valid !== 1'b1 || IF_pc !== 8'h40 + 8'(i) || IF_Instr !== 32'hA800_0040 + 32'(i) || flush !== 1'b0) begin
        n_fail++;
        $display("FAIL branch_target[%0d]: valid=%b pc=%h instr=%h flush=%b, want 1 %h %h 0",
                 i, IF_valid, IF_pc, IF_Instr, flush, 8'h40 + 8'(i), 32'hA800_0040 + 32'(i));
      end
    end
  endtask

  task automatic test_branch_with_stall();
    drive(0, 0, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 1, 8'h10);
    n_checks++;
    if (flush !== 1'b1 || imem_en !== 1'b1 || imem_addr !== 8'h10 || IF_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL branch_stall_cycle: flush=%b en=%b addr=%h valid=%b, want 1 1 10 0",
               flush, imem_en, imem_addr, IF_valid);
    end
    drive(0, 0, 0, 8'h00);
    n_checks++;
    if (IF_valid !== 1'b1 || IF_pc !== 8'h10 || IF_Instr !== 32'hA800_0010) begin
      n_fail++;
      $display("FAIL branch_stall_next: valid=%b pc=%h instr=%h, want 1 10 a8000010", IF_valid, IF_pc, IF_Instr);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want;
    drive(0, 0, 1, 8'hFF);
    want = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 8'h00);
      n_checks++;
      if (IF_valid !== 1'b1 || IF_pc !== want || IF_Instr !== 32'hA800_0000 + 32'(want)) begin
        n_fail++;
        $display("FAIL wrap[%0d]: valid=%b pc=%h instr=%h, want 1 %h %h",
                 i, IF_valid, IF_pc, IF_Instr, want, 32'hA800_0000 + 32'(want));
      end
      want = want + 8'd1;
    end
  endtask

  task automatic test_random();
    logic r, s, b;
    logic [7:0] t;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 9) == 0);
      t = 8'($urandom_range(0, 255));
      drive(r, s, b, t);
      n_checks++;
      if (IF_valid !== exp_valid() || IF_Instr !== exp_instr() || (exp_valid() && IF_pc !== m_pc)) begin
        n_fail++;
        $display("FAIL rand_out[%0d]: valid=%b pc=%h instr=%h, want %b %h %h",
                 i, IF_valid, IF_pc, IF_Instr, exp_valid(), m_pc, exp_instr());
      end
      n_checks++;
      if (imem_en !== exp_en() || (exp_en() && imem_addr !== exp_addr()) || flush !== (!r && b)) begin
        n_fail++;
        $display("FAIL rand_mem[%0d]: en=%b addr=%h flush=%b, want %b %h %b",
                 i, imem_en, imem_addr, flush, exp_en(), exp_addr(), (!r && b));
      end
`ifdef IF_PERF_CNT_EN
      n_checks++;
      if (perf_fetch_cnt !== m_fetch_cnt || perf_stall_cnt !== m_stall_cnt) begin
        n_fail++;
        $display("FAIL rand_perf[%0d]: fetch=%0d stall=%0d, want %0d %0d",
                 i, perf_fetch_cnt, perf_stall_cnt, m_fetch_cnt, m_stall_cnt);
      end
`endif
    end
  endtask

  task automatic test_reset_during_stall();
    drive(0, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    drive(0, 1, 0, 8'h00);
    drive(1, 1, 0, 8'h00);
    n_checks++;
    if (IF_valid !== 1'b0 || imem_en !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_stall: valid=%b en=%b, want 0 0", IF_valid, imem_en);
    end
    drive(0, 0, 0, 8'h00);
    n_checks++;
    if (IF_valid !== 1'b0 || IF_Instr !== NOP || imem_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_stall_bubble: valid=%b instr=%h addr=%h, want 0 %h 00", IF_valid, IF_Instr, imem_addr, NOP);
    end
`ifdef IF_PERF_CNT_EN
    n_checks++;
    if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rst_perf_clear: fetch=%0d stall=%0d, want 0 0", perf_fetch_cnt, perf_stall_cnt);
    end
`endif
    drive(0, 0, 0, 8'h00);
    n_checks++;
    if (IF_valid !== 1'b1 || IF_pc !== 8'h00 || IF_Instr !== 32'hA800_0000) begin
      n_fail++;
      $display("FAIL rst_restart: valid=%b pc=%h instr=%h, want 1 00 a8000000", IF_valid, IF_pc, IF_Instr);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA800_0000 + 32'(i);
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    test_reset();
    test_stall();
    test_branch();
    test_branch_with_stall();
    test_wrap();
    test_reset_during_stall();
    test_random();
    test_reset_during_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction fetch stage for the Cardinal pipeline. Sits ahead of the IF/ID decode register.
- Owns the PC and drives a synchronous-read instruction memory (1-cycle read latency).
- Presents one 32-bit instruction per cycle to decode, and honours stall from the hazard unit.
- Takes branch redirects from EX and generates the IF/ID flush.

Parameters:
- ADDR_W, 8, PC / imem word-address width; 256-word imem; PC increments by 1 word.
- RESET_PC, 0, first fetch address after reset.
- NOP_INSTR, 32'hE000_0000, instruction driven when no valid fetch exists (opcode field 6'b111000).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; same signal that holds IF/ID
- branch_taken  in  1  one-cycle redirect pulse from EX
- branch_target  in  ADDR_W  redirect word address, valid with branch_taken
- imem_addr  out  ADDR_W  instruction memory read address
- imem_en  out  1  instruction memory read enable
- imem_dout  in  32  read data; equals mem[imem_addr] sampled at the previous edge when imem_en was 1
- IF_Instr  out  32  instruction to decode (bit 0 = MSB, opcode in [0:5])
- IF_pc  out  ADDR_W  word address of IF_Instr
- IF_valid  out  1  IF_Instr is a real fetched instruction
- flush  out  1  flush request to IF/ID

Behaviour:
Internal state:
- pc_q: next address to issue.
- pend_valid / pend_pc: a read was issued last cycle.
- hold_valid / hold_instr / hold_pc: skid register.

Output mux (combinational):
- hold_valid=1 -> hold_instr / hold_pc, IF_valid=1.
- else pend_valid=1 -> imem_dout / pend_pc, IF_valid=1.
- else -> NOP_INSTR, IF_pc=pend_pc, IF_valid=0.
- branch_taken=1 overrides all of the above: IF_Instr=NOP_INSTR, IF_valid=0.

Reset:
- While rst=1: imem_en=0 and flush=0; IF_Instr=NOP_INSTR and IF_valid=0.
- At the edge: pc_q=RESET_PC, pend_valid=0, hold_valid=0.
- First cycle after rst: issue RESET_PC. First valid IF_Instr appears one cycle later (1-cycle fill bubble).
- Reset mid-operation discards pending and held instructions, no exceptions.

Cycle rules, in priority order:
1. branch_taken=1 (wins over stall):
   - imem_addr=branch_target, imem_en=1, flush=1.
   - Next edge: pc_q=branch_target+1, pend_valid=1, pend_pc=branch_target, hold_valid=0.
   - mem[target] is presented the following cycle.
2. stall=1:
   - imem_en=0 and pc_q frozen.
   - If hold_valid=0: capture the current output (instr, pc, valid) into hold; hold_valid<=current IF_valid.
   - pend_valid<=0.
   - Output stays constant for the whole stall.
3. Run:
   - imem_addr=pc_q, imem_en=1, pc_q<=pc_q+1, pend_valid<=1, pend_pc<=pc_q.
   - hold_valid<=0. The held instruction is consumed by IF/ID at this edge.

Arithmetic and boundaries:
- PC arithmetic is modulo 2^ADDR_W: 255+1 wraps to 0, and branch_target=255 gives pc_q=0.
- Stall during the reset-fill bubble holds NOP with IF_valid=0.
- Back-to-back branch_taken: each redirect takes effect; the last one wins.
- branch_taken together with stall: redirect happens and hold is cleared. The hazard unit guarantees IF/ID sees flush (IF/ID gives stall priority, so the hazard unit deasserts stall on redirect).
- flush is combinational from branch_taken, zero latency.
- imem_en is never 1 while rst=1 or while stall=1 without a branch.

Optional Feature:
Macro IF_PERF_CNT_EN.
- Defined:
  - Adds output perf_fetch_cnt [32], which increments on each edge where the decoder consumes a valid instruction (IF_valid=1, stall=0, branch_taken=0).
  - Adds output perf_stall_cnt [32], which increments on each edge with stall=1.
  - Both counters clear on rst and wrap at 2^32.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
1. Reset then free-run, imem[i]=32'hA800_0000+i:
   - cycle 1 after rst: IF_valid=0, IF_Instr=32'hE000_0000.
   - cycles 2..5: IF_pc=0,1,2,3 with matching instructions.
2. Stall for 3 cycles while IF_pc=4:
   - IF_Instr=imem[4] and IF_pc=4 are held for all 3 stall cycles plus the release cycle.
   - imem_en=0 during the stall; next cycle shows IF_pc=5 with nothing skipped or duplicated.
3. branch_taken with branch_target=8'h40 while IF_pc=6:
   - that cycle: flush=1, IF_valid=0, imem_addr=8'h40.
   - next cycle: IF_pc=8'h40.
   - then 8'h41.
4. branch_taken and stall asserted in the same cycle, target 8'h10:
   - redirect wins and hold is cleared.
   - next cycle with stall=0 shows IF_pc=8'h10.
5. Wrap: branch_target=8'hFF, then run:
   - IF_pc sequence FF, 00, 01.
6. rst asserted during a stall with hold_valid=1:
   - next cycle: IF_valid=0.
   - after release: fetch restarts at RESET_PC.
   - with IF_PERF_CNT_EN defined, both counters read 0.
